// File: rtl/option_rom_loader.sv
// Boot loader: streams the option ROM image from SPI flash (READ 0x03, mode 0) into the
// option ROM BRAM, validates header/checksum and gates the ISA decoder via rom_valid.
module option_rom_loader #(
  parameter logic [23:0] FLASH_BASE   = 24'h100000,
  parameter int unsigned ROM_SIZE_KB  = 16,
  parameter int unsigned SPI_DIV      = 2,
  parameter bit          AUTO_START   = 1'b1,
  parameter bit          FIX_CHECKSUM = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        bram_we,
  output logic [14:0] bram_addr,
  output logic [7:0]  bram_wdata,
  output logic        busy,
  output logic        load_done,
  output logic        rom_valid,
  output logic        err_sig,
  output logic        err_size,
  output logic        err_csum,
  output logic [15:0] image_bytes
);

  localparam logic [15:0] ROM_END  = 16'(ROM_SIZE_KB * 1024);
  localparam logic [7:0]  MAX_SIZE = 8'(ROM_SIZE_KB * 2);
  localparam int unsigned DW       = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SPI_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_DATA  = 3'd2,
    S_FILL  = 3'd3,
    S_PATCH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state;
  logic          auto_pend;
  logic [DW-1:0] div_cnt;
  logic [31:0]   cmd_sr;
  logic [5:0]    rise_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    shift_q;
  logic [15:0]   idx;
  logic [7:0]    sum;
  logic [7:0]    last_byte;
  logic [1:0]    sig_ok;
  logic          last_pend;

  logic       tick;
  logic       rise;
  logic       fall;
  logic       start_ok;
  logic [7:0] new_byte;

  assign tick     = (div_cnt == DIV_LAST);
  assign rise     = tick && !spi_sck;
  assign fall     = tick && spi_sck;
  assign new_byte = {shift_q, spi_miso};
  assign start_ok = (start || auto_pend) && (state == S_IDLE || state == S_DONE);
  assign spi_mosi = cmd_sr[31];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      auto_pend   <= AUTO_START;
      div_cnt     <= '0;
      cmd_sr      <= '0;
      rise_cnt    <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      idx         <= '0;
      sum         <= '0;
      last_byte   <= '0;
      sig_ok      <= '0;
      last_pend   <= 1'b0;
      spi_sck     <= 1'b0;
      spi_cs_n    <= 1'b1;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_wdata  <= '0;
      busy        <= 1'b0;
      load_done   <= 1'b0;
      rom_valid   <= 1'b0;
      err_sig     <= 1'b0;
      err_size    <= 1'b0;
      err_csum    <= 1'b0;
      image_bytes <= '0;
    end else begin
      bram_we <= 1'b0;
      if (state == S_CMD || state == S_DATA) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) spi_sck <= ~spi_sck;
        if (fall) cmd_sr <= {cmd_sr[30:0], 1'b0};
      end else begin
        div_cnt <= '0;
        spi_sck <= 1'b0;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state       <= S_CMD;
            auto_pend   <= 1'b0;
            spi_cs_n    <= 1'b0;
            cmd_sr      <= {8'h03, FLASH_BASE};
            rise_cnt    <= '0;
            bit_cnt     <= '0;
            idx         <= '0;
            sum         <= '0;
            sig_ok      <= '0;
            last_pend   <= 1'b0;
            busy        <= 1'b1;
            load_done   <= 1'b0;
            rom_valid   <= 1'b0;
            err_sig     <= 1'b0;
            err_size    <= 1'b0;
            err_csum    <= 1'b0;
            image_bytes <= '0;
          end
        end
        S_CMD: begin
          if (rise) begin
            rise_cnt <= rise_cnt + 1'b1;
            if (rise_cnt == 6'd31) state <= S_DATA;
          end
        end
        S_DATA: begin
          if (rise) begin
            shift_q <= new_byte[6:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              bram_we    <= 1'b1;
              bram_addr  <= idx[14:0];
              bram_wdata <= new_byte;
              sum        <= sum + new_byte;
              idx        <= idx + 1'b1;
              if (idx == 16'd0) sig_ok[0] <= (new_byte == 8'h55);
              if (idx == 16'd1) sig_ok[1] <= (new_byte == 8'hAA);
              if (idx == 16'd2) begin
                if (sig_ok != 2'b11) err_sig <= 1'b1;
                else if (new_byte == 8'd0 || new_byte > MAX_SIZE) err_size <= 1'b1;
                else image_bytes <= {new_byte[6:0], 9'd0};
              end
              if (idx == image_bytes - 16'd1) begin
                last_pend <= 1'b1;
                last_byte <= new_byte;
              end
            end
          end else if (bram_we) begin
            // Leave DATA only once the pending byte write has been presented, so header
            // bytes still land in BRAM and bram_we never overlaps DONE.
            if (err_sig || err_size) begin
              state     <= S_DONE;
              spi_cs_n  <= 1'b1;
              spi_sck   <= 1'b0;
              busy      <= 1'b0;
              load_done <= 1'b1;
              rom_valid <= 1'b0;
            end else if (last_pend) begin
              state    <= S_FILL;
              spi_cs_n <= 1'b1;
              spi_sck  <= 1'b0;
            end
          end
        end
        S_FILL: begin
          if (idx < ROM_END) begin
            bram_we    <= 1'b1;
            bram_addr  <= idx[14:0];
            bram_wdata <= 8'hFF;
            idx        <= idx + 1'b1;
          end else begin
            // Patch write is issued here so it is active during the PATCH cycle itself.
            state <= S_PATCH;
            if (sum != 8'd0) begin
              if (FIX_CHECKSUM) begin
                bram_we    <= 1'b1;
                bram_addr  <= image_bytes[14:0] - 15'd1;
                bram_wdata <= last_byte - sum;
              end else begin
                err_csum <= 1'b1;
              end
            end
          end
        end
        S_PATCH: begin
          state     <= S_DONE;
          busy      <= 1'b0;
          load_done <= 1'b1;
          rom_valid <= !err_csum;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_option_rom_loader.sv
// Bench for option_rom_loader: two instances (checksum fix on/off) each fed by a
// behavioural mode-0 SPI flash, with a BRAM write scoreboard and directed sequences.
module tb_option_rom_loader;

  localparam int unsigned ROM_KB     = 8;
  localparam int unsigned ROM_BYTES  = ROM_KB * 1024;
  localparam int unsigned IMG_BYTES  = 512;
  localparam int unsigned LOAD_LIMIT = 40000;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic       exp_sig;
    logic       exp_size;
  } hdr_vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_v [2];
  logic sck_v [2], csn_v [2], mosi_v [2], miso_v [2], we_v [2];
  logic busy_v [2], done_v [2], valid_v [2], esig_v [2], esize_v [2], ecsum_v [2];
  logic [14:0] addr_v [2];
  logic [7:0]  wdata_v [2];
  logic [15:0] ibytes_v [2];

  logic [7:0]  img [2][ROM_BYTES];
  logic [7:0]  sh  [2][ROM_BYTES];
  int unsigned wcnt [2], nloads [2], bad_we [2];
  logic [14:0] first_a [2], last_a [2];
  logic [7:0]  last_d [2];
  logic        prev_cs [2];
  logic        sb_clr [2];

  int checks = 0;
  int errors = 0;
  hdr_vec_t hv [5];

  always #5 clk = ~clk;

  option_rom_loader #(.FLASH_BASE(24'h100000), .ROM_SIZE_KB(ROM_KB), .SPI_DIV(2),
                      .AUTO_START(1'b1), .FIX_CHECKSUM(1'b1)) u_fix (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]),
    .spi_sck(sck_v[0]), .spi_cs_n(csn_v[0]), .spi_mosi(mosi_v[0]), .spi_miso(miso_v[0]),
    .bram_we(we_v[0]), .bram_addr(addr_v[0]), .bram_wdata(wdata_v[0]),
    .busy(busy_v[0]), .load_done(done_v[0]), .rom_valid(valid_v[0]),
    .err_sig(esig_v[0]), .err_size(esize_v[0]), .err_csum(ecsum_v[0]),
    .image_bytes(ibytes_v[0])
  );

  option_rom_loader #(.FLASH_BASE(24'h100000), .ROM_SIZE_KB(ROM_KB), .SPI_DIV(2),
                      .AUTO_START(1'b0), .FIX_CHECKSUM(1'b0)) u_nofix (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]),
    .spi_sck(sck_v[1]), .spi_cs_n(csn_v[1]), .spi_mosi(mosi_v[1]), .spi_miso(miso_v[1]),
    .bram_we(we_v[1]), .bram_addr(addr_v[1]), .bram_wdata(wdata_v[1]),
    .busy(busy_v[1]), .load_done(done_v[1]), .rom_valid(valid_v[1]),
    .err_sig(esig_v[1]), .err_size(esize_v[1]), .err_csum(ecsum_v[1]),
    .image_bytes(ibytes_v[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_flash
    int unsigned rises = 0;
    logic [31:0] cmd = '0;
    time t_first = 0;
    time period = 0;

    // Flash: samples MOSI on SCK rise, shifts image bits out MSB first on SCK fall.
    always @(posedge sck_v[g] or posedge csn_v[g]) begin
      if (csn_v[g]) begin
        rises <= 0;
      end else begin
        if (rises == 0) t_first <= $time;
        if (rises == 1) period <= $time - t_first;
        if (rises < 32) cmd <= {cmd[30:0], mosi_v[g]};
        rises <= rises + 1;
      end
    end

    always @(negedge sck_v[g] or posedge csn_v[g]) begin
      if (csn_v[g]) miso_v[g] <= 1'b0;
      else if (rises >= 32 && (rises - 32) / 8 < ROM_BYTES)
        miso_v[g] <= img[g][(rises - 32) / 8][3'(7 - ((rises - 32) % 8))];
    end

    always @(negedge clk) begin
      if (sb_clr[g]) begin
        wcnt[g]   <= 0;
        nloads[g] <= 0;
        bad_we[g] <= 0;
        for (int unsigned i = 0; i < ROM_BYTES; i++) sh[g][i] <= 8'h00;
      end else begin
        if (prev_cs[g] && !csn_v[g]) nloads[g] <= nloads[g] + 1;
        if (we_v[g]) begin
          if (wcnt[g] == 0) first_a[g] <= addr_v[g];
          sh[g][addr_v[g]] <= wdata_v[g];
          last_a[g] <= addr_v[g];
          last_d[g] <= wdata_v[g];
          wcnt[g]   <= wcnt[g] + 1;
          if (!busy_v[g]) bad_we[g] <= bad_we[g] + 1;
        end
      end
      prev_cs[g] <= csn_v[g];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_sb(input int g);
    sb_clr[g] = 1'b1;
    @(negedge clk);
    #1;
    sb_clr[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input string name);
    int unsigned n = 0;
    while (!done_v[g] && n < LOAD_LIMIT) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({name, "_load_done"}, 32'(done_v[g]), 32'd1);
  endtask

  // 512-byte image 55 AA 01 ..., last byte 0x00, byte 3 tuned so the sum is target.
  task automatic make_image(input int g, input logic [7:0] target);
    logic [7:0] s;
    for (int unsigned i = 0; i < ROM_BYTES; i++) img[g][i] = 8'h5A;
    img[g][0] = 8'h55;
    img[g][1] = 8'hAA;
    img[g][2] = 8'h01;
    for (int unsigned i = 3; i < IMG_BYTES - 1; i++) img[g][i] = 8'(i * 7 + 3);
    img[g][IMG_BYTES-1] = 8'h00;
    s = 8'h00;
    for (int unsigned i = 0; i < IMG_BYTES; i++) s = s + img[g][i];
    img[g][3] = img[g][3] + (target - s);
  endtask

  task automatic check_load(input int g, input string name, input int unsigned exp_writes,
                            input logic patched, input logic [7:0] pval);
    int unsigned dmis = 0;
    int unsigned fmis = 0;
    logic [7:0] e;
    for (int unsigned i = 0; i < IMG_BYTES; i++) begin
      e = img[g][i];
      if (patched && i == IMG_BYTES - 1) e = pval;
      if (sh[g][i] !== e) dmis++;
    end
    for (int unsigned i = IMG_BYTES; i < ROM_BYTES; i++)
      if (sh[g][i] !== 8'hFF) fmis++;
    chk({name, "_data_bytes_wrong"}, dmis, 0);
    chk({name, "_fill_bytes_wrong"}, fmis, 0);
    chk({name, "_write_count"}, wcnt[g], exp_writes);
    chk({name, "_we_while_idle"}, bad_we[g], 0);
    chk({name, "_cs_assertions"}, nloads[g], 1);
    chk({name, "_busy"}, 32'(busy_v[g]), 0);
    chk({name, "_cs_n"}, 32'(csn_v[g]), 1);
    chk({name, "_image_bytes"}, 32'(ibytes_v[g]), IMG_BYTES);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    hv[0] = '{8'h55, 8'hAB, 8'h01, 1'b1, 1'b0};
    hv[1] = '{8'hAA, 8'h55, 8'h01, 1'b1, 1'b0};
    hv[2] = '{8'h55, 8'hAA, 8'h00, 1'b0, 1'b1};
    hv[3] = '{8'h55, 8'hAA, 8'h11, 1'b0, 1'b1};
    hv[4] = '{8'h55, 8'hAA, 8'h40, 1'b0, 1'b1};
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    sb_clr[0]  = 1'b0;
    sb_clr[1]  = 1'b0;
    make_image(0, 8'h00);
    make_image(1, 8'h37);

    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(csn_v[0]), 1);
    chk("rst_sck", 32'(sck_v[0]), 0);
    chk("rst_mosi", 32'(mosi_v[0]), 0);
    chk("rst_we", 32'(we_v[0]), 0);
    chk("rst_busy", 32'(busy_v[0]), 0);
    chk("rst_done", 32'(done_v[0]), 0);
    chk("rst_valid", 32'(valid_v[0]), 0);
    chk("rst_image_bytes", 32'(ibytes_v[0]), 0);
    chk("rst_cs_n_nofix", 32'(csn_v[1]), 1);
    clear_sb(0);
    clear_sb(1);

    // Auto start on the first clock after release; interrupt with reset at byte 100.
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("auto_busy", 32'(busy_v[0]), 1);
    chk("auto_cs_n", 32'(csn_v[0]), 0);
    chk("noauto_busy", 32'(busy_v[1]), 0);
    n = 0;
    while (wcnt[0] < 101 && n < LOAD_LIMIT) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("partial_writes", wcnt[0], 101);
    chk("partial_first_addr", 32'(first_a[0]), 0);
    chk("mosi_first_32", g_flash[0].cmd, 32'h03100000);
    chk("sck_period", 32'(g_flash[0].period), 40);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_cs_n", 32'(csn_v[0]), 1);
    chk("async_rst_we", 32'(we_v[0]), 0);
    chk("async_rst_busy", 32'(busy_v[0]), 0);
    chk("async_rst_sck", 32'(sck_v[0]), 0);
    repeat (2) @(negedge clk);
    clear_sb(0);

    // Reload from address 0 after release; a mid-load start must be ignored.
    reset_n = 1'b1;
    n = 0;
    while (wcnt[0] < 200 && n < LOAD_LIMIT) begin
      @(negedge clk);
      n++;
    end
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, "good");
    chk("good_first_addr", 32'(first_a[0]), 0);
    chk("good_rom_valid", 32'(valid_v[0]), 1);
    chk("good_err_sig", 32'(esig_v[0]), 0);
    chk("good_err_size", 32'(esize_v[0]), 0);
    chk("good_err_csum", 32'(ecsum_v[0]), 0);
    check_load(0, "good", ROM_BYTES, 1'b0, 8'h00);
    chk("nofix_still_idle", 32'(busy_v[1]), 0);
    chk("nofix_no_done", 32'(done_v[1]), 0);

    // Checksum 0x37 image: patched on u_fix, flagged on u_nofix; u_fix restarts from DONE.
    make_image(0, 8'h37);
    clear_sb(0);
    clear_sb(1);
    start_v[0] = 1'b1;
    start_v[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_valid_drop", 32'(valid_v[0]), 0);
    chk("restart_busy", 32'(busy_v[0]), 1);
    chk("restart_done_clear", 32'(done_v[0]), 0);
    @(negedge clk);
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    wait_done(0, "patch");
    wait_done(1, "nofix");
    chk("patch_last_addr", 32'(last_a[0]), 32'(IMG_BYTES - 1));
    chk("patch_last_data", 32'(last_d[0]), 32'h0C9);
    chk("patch_rom_valid", 32'(valid_v[0]), 1);
    chk("patch_err_csum", 32'(ecsum_v[0]), 0);
    check_load(0, "patch", ROM_BYTES + 1, 1'b1, 8'hC9);
    chk("nofix_err_csum", 32'(ecsum_v[1]), 1);
    chk("nofix_rom_valid", 32'(valid_v[1]), 0);
    chk("nofix_last_addr", 32'(last_a[1]), 32'(ROM_BYTES - 1));
    chk("nofix_last_data", 32'(last_d[1]), 32'h0FF);
    check_load(1, "nofix", ROM_BYTES, 1'b0, 8'h00);

    // Header rejection vectors: exactly bytes 0-2 written, then abort.
    for (int r = 0; r < 5; r++) begin
      img[0][0] = hv[r].b0;
      img[0][1] = hv[r].b1;
      img[0][2] = hv[r].b2;
      clear_sb(0);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_done(0, $sformatf("hdr%0d", r));
      repeat (8) @(negedge clk);
      #1;
      chk($sformatf("hdr%0d_err_sig", r), 32'(esig_v[0]), 32'(hv[r].exp_sig));
      chk($sformatf("hdr%0d_err_size", r), 32'(esize_v[0]), 32'(hv[r].exp_size));
      chk($sformatf("hdr%0d_rom_valid", r), 32'(valid_v[0]), 0);
      chk($sformatf("hdr%0d_writes", r), wcnt[0], 3);
      chk($sformatf("hdr%0d_byte2", r), 32'(sh[0][2]), 32'(hv[r].b2));
      chk($sformatf("hdr%0d_cs_n", r), 32'(csn_v[0]), 1);
      chk($sformatf("hdr%0d_busy", r), 32'(busy_v[0]), 0);
      chk($sformatf("hdr%0d_we_idle", r), bad_we[0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
